user_str_fifo: RTL and testbench

Elastic buffer for one 64-bit PCIe stream channel. It sits between the PCIe stream engine's host-to-card output and the user-logic adapter's stream input, and absorbs back-pressure from user logic so the DMA side keeps moving. One instance per stream is placed in front of each `i_pcie_strN_*` input of the user-logic top. The buffer is first-word-fall-through and uses the same valid/ack handshake on both sides.

---
 rtl/user_str_pkg.sv | 9 +
 rtl/user_str_fifo.sv | 94 +++++++++
 tb/tb_user_str_fifo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/user_str_pkg.sv
// Shared stream definitions for the PCIe stream channel and the user-logic adapter.
package user_str_pkg;

  localparam int STR_DATA_WIDTH     = 64;
  localparam int STR_FIFO_DEPTH_DEF = 16;

  typedef logic [STR_DATA_WIDTH-1:0] str_word_t;

endpackage : user_str_pkg

// File: rtl/user_str_fifo.sv
// First-word-fall-through elastic buffer for one PCIe stream channel (valid/ack on both sides).
// Optional statistics (word counter, high-water mark) are built when USER_STR_FIFO_STATS_EN is defined.
module user_str_fifo
  import user_str_pkg::*;
#(
  parameter int DATA_WIDTH = STR_DATA_WIDTH,
  parameter int DEPTH      = STR_FIFO_DEPTH_DEF
) (
  input  logic                    i_user_clk,
  input  logic                    i_rst,
  input  logic                    i_pcie_str_data_valid,
  output logic                    o_pcie_str_ack,
  input  logic [DATA_WIDTH-1:0]   i_pcie_str_data,
  output logic                    o_adpt_str_data_valid,
  input  logic                    i_adpt_str_ack,
  output logic [DATA_WIDTH-1:0]   o_adpt_str_data,
  output logic [$clog2(DEPTH):0]  o_fill_level,
`ifdef USER_STR_FIFO_STATS_EN
  output logic [31:0]             o_str_word_cnt,
  output logic [$clog2(DEPTH):0]  o_max_level,
`endif
  output logic                    o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         fill_q, fill_d;
  logic                  full_q;
  logic                  push, pop;

  // Push looks only at registered full, so a same-cycle pop never frees a slot early.
  assign push = i_pcie_str_data_valid & ~full_q & ~i_rst;
  assign pop  = (fill_q != '0) & i_adpt_str_ack;

  assign o_pcie_str_ack        = push;
  assign o_adpt_str_data_valid = (fill_q != '0);
  assign o_adpt_str_data       = mem_q[rd_ptr_q];
  assign o_fill_level          = fill_q;
  assign o_full                = full_q;

  // NOTE: always_comb assigns a default first so no path leaves fill_d unassigned (no latch).
  always_comb begin
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + LW'(1);
      2'b01:   fill_d = fill_q - LW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      full_q <= (fill_d == FULL_LEVEL);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by fill_q, and a
  // reset-free array maps onto distributed RAM instead of a wide reset tree.
  always_ff @(posedge i_user_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_pcie_str_data;
  end

`ifdef USER_STR_FIFO_STATS_EN
  logic [31:0]   cnt_q;
  logic [LW-1:0] max_q;

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      max_q <= '0;
    end else begin
      if (pop)            cnt_q <= cnt_q + 32'd1;
      if (fill_d > max_q) max_q <= fill_d;
    end
  end

  assign o_str_word_cnt = cnt_q;
  assign o_max_level    = max_q;
`endif

endmodule : user_str_fifo

// File: tb/tb_user_str_fifo.sv
// Self-checking bench for user_str_fifo: a per-cycle vector table plus directed multi-cycle sequences.
module tb_user_str_fifo;

  localparam int DW = 64;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ack;
  logic [DW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ack;
  logic [DW-1:0] dn_data;
  logic [4:0]    fill;
  logic          full;
`ifdef USER_STR_FIFO_STATS_EN
  logic [31:0]   word_cnt;
  logic [4:0]    max_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  user_str_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_user_clk            (clk),
    .i_rst                 (rst),
    .i_pcie_str_data_valid (up_valid),
    .o_pcie_str_ack        (up_ack),
    .i_pcie_str_data       (up_data),
    .o_adpt_str_data_valid (dn_valid),
    .i_adpt_str_ack        (dn_ack),
    .o_adpt_str_data       (dn_data),
    .o_fill_level          (fill),
`ifdef USER_STR_FIFO_STATS_EN
    .o_str_word_cnt        (word_cnt),
    .o_max_level           (max_level),
`endif
    .o_full                (full)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          exp_up_ack;
    logic          exp_dn_valid;
    logic [DW-1:0] exp_dn_data;
    logic [4:0]    exp_fill;
    logic          exp_full;
  } vec_t;

  vec_t vecs[10];
  logic [DW-1:0] sb[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic a);
    up_valid = v;
    up_data  = d;
    dn_ack   = a;
    #1;
  endtask

  initial begin
    int accepted;
    int idx;
    logic [DW-1:0] exp_w;

    rst = 1'b1;
    up_valid = 1'b0;
    up_data = '0;
    dn_ack = 1'b0;

    // Streaming pass-through: each word appears one cycle after its push.
    vecs[0] = '{1'b1, 64'h1111, 1'b1, 1'b1, 1'b0, 64'h0, 5'd0, 1'b0};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{1'b1, 64'h1111 + DW'(i), 1'b1, 1'b1, 1'b1, 64'h1111 + DW'(i - 1), 5'd1, 1'b0};
    vecs[8] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h1118, 5'd1, 1'b0};
    vecs[9] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0};

    tick();
    drive(1'b1, 64'h5555, 1'b0);
    check("ack_during_reset", DW'(up_ack), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("reset_valid", DW'(dn_valid), 64'd0);
    check("reset_fill", DW'(fill), 64'd0);
    check("reset_full", DW'(full), 64'd0);
`ifdef USER_STR_FIFO_STATS_EN
    check("reset_cnt", DW'(word_cnt), 64'd0);
    check("reset_max", DW'(max_level), 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].a);
      check($sformatf("vec%0d_up_ack", i), DW'(up_ack), DW'(vecs[i].exp_up_ack));
      check($sformatf("vec%0d_dn_valid", i), DW'(dn_valid), DW'(vecs[i].exp_dn_valid));
      if (vecs[i].exp_dn_valid)
        check($sformatf("vec%0d_dn_data", i), dn_data, vecs[i].exp_dn_data);
      check($sformatf("vec%0d_fill", i), DW'(fill), DW'(vecs[i].exp_fill));
      check($sformatf("vec%0d_full", i), DW'(full), DW'(vecs[i].exp_full));
      tick();
    end

    // Fill to capacity with downstream stalled; words 17..20 stay pending.
    accepted = 0;
    for (int c = 0; c < 25; c++) begin
      drive(accepted < 20, 64'h2000 + DW'(accepted + 1), 1'b0);
      if (up_ack) accepted++;
      tick();
    end
    drive(1'b1, 64'h2000 + DW'(accepted + 1), 1'b0);
    check("full_accepted", DW'(accepted), 64'd16);
    check("full_flag", DW'(full), 64'd1);
    check("full_fill", DW'(fill), 64'd16);
    check("full_up_ack", DW'(up_ack), 64'd0);

    // One-cycle downstream pulse from full: upstream ack comes back a cycle later.
    drive(1'b1, 64'h2011, 1'b1);
    check("pulse_head", dn_data, 64'h2001);
    check("pulse_up_ack_same", DW'(up_ack), 64'd0);
    tick();
    drive(1'b1, 64'h2011, 1'b0);
    check("pulse_fill", DW'(fill), 64'd15);
    check("pulse_full", DW'(full), 64'd0);
    check("pulse_up_ack_next", DW'(up_ack), 64'd1);
    tick();
    drive(1'b0, '0, 1'b1);
    check("refull_flag", DW'(full), 64'd1);
    for (int i = 2; i <= 17; i++) begin
      drive(1'b0, '0, 1'b1);
      check($sformatf("order_valid%0d", i), DW'(dn_valid), 64'd1);
      check($sformatf("order_word%0d", i), dn_data, 64'h2000 + DW'(i));
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("drained_valid", DW'(dn_valid), 64'd0);
    check("drained_fill", DW'(fill), 64'd0);

    // Preload 5 words, then push and pop together for 100 cycles.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h3000 + DW'(i), 1'b0);
      sb.push_back(64'h3000 + DW'(i));
      tick();
    end
    idx = 5;
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 64'h3000 + DW'(idx), 1'b1);
      exp_w = sb.pop_front();
      check("steady_data", dn_data, exp_w);
      if (up_ack) begin
        sb.push_back(64'h3000 + DW'(idx));
        idx++;
      end
      tick();
      check("steady_fill", DW'(fill), 64'd5);
    end
    while (sb.size() > 0) begin
      drive(1'b0, '0, 1'b1);
      exp_w = sb.pop_front();
      check("tail_data", dn_data, exp_w);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("tail_empty", DW'(dn_valid), 64'd0);

    // Reset with 10 words stored discards them.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h4000 + DW'(i), 1'b0);
      tick();
    end
    check("pre_rst_fill", DW'(fill), 64'd10);
    rst = 1'b1;
    drive(1'b1, 64'h4444, 1'b0);
    check("rst_up_ack", DW'(up_ack), 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("post_rst_valid", DW'(dn_valid), 64'd0);
    check("post_rst_fill", DW'(fill), 64'd0);
    drive(1'b1, 64'hAB, 1'b0);
    check("ab_not_visible", DW'(dn_valid), 64'd0);
    tick();
    drive(1'b0, '0, 1'b1);
    check("ab_valid", DW'(dn_valid), 64'd1);
    check("ab_data", dn_data, 64'hAB);
    check("ab_fill", DW'(fill), 64'd1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("ab_alone", DW'(dn_valid), 64'd0);

`ifdef USER_STR_FIFO_STATS_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h5000 + DW'(i), 1'b0);
      tick();
    end
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("cnt_wrap", DW'(word_cnt), 64'd1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 64'h6000 + DW'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("max_12", DW'(max_level), 64'd12);
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    drive(1'b0, '0, 1'b0);
    check("max_hold", DW'(max_level), 64'd12);
    check("max_fill", DW'(fill), 64'd10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_user_str_fifo
